mem_ctrl: RTL and testbench

Multi-cycle SRAM access controller between the SLC-3 control unit/datapath (MAR, MDR) and the external asynchronous SRAM. It accepts one read or write request at a time and generates the active-low SRAM strobes over a fixed number of wait cycles. It returns read data with a one-cycle `done` pulse, so the control unit waits on a handshake instead of hard-coding cycle counts per memory state. An optional I/O window maps address 0xFFFF to the board switches (read) and the hex-display register (write).

---
 rtl/slc3_pkg.sv | 16 +
 rtl/mem_wait_cnt.sv | 21 ++
 rtl/mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 memory controller.
package slc3_pkg;

  localparam int          WORD_W  = 16;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    RD_DONE,
    WR_SETUP,
    WR_ACC,
    WR_DONE
  } mem_state_t;

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable 4-bit down-counter timing the SRAM strobe width; zero_o flags the last cycle.
module mem_wait_cnt (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                    cnt_q <= 4'd0;
    else if (load_i)               cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0)  cnt_q <= cnt_q - 4'd1;
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_ctrl.sv
// Multi-cycle SRAM access controller with done handshake.
// Optional MEM_IO_MAP_EN maps 0xFFFF to switches (read) and hex register (write).
module mem_ctrl
  import slc3_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              done,
  output logic              busy,
  input  logic [15:0]       sw,
  output logic [15:0]       hex_out,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  mem_state_t        state_q, state_d;
  logic [WORD_W-1:0] addr_q, wdata_q, rdata_q;
  logic              accept, rd_cap, cnt_load, cnt_en, cnt_zero, io_hit;

`ifdef MEM_IO_MAP_EN
  logic [WORD_W-1:0] hex_q;
  assign io_hit  = (addr_q == IO_ADDR);
  assign hex_out = hex_q;
`else
  logic unused_sw;
  assign unused_sw = ^sw;
  assign io_hit    = 1'b0;
  assign hex_out   = '0;
`endif

  mem_wait_cnt u_wait (
    .Clk       (Clk),
    .Reset     (Reset),
    .load_i    (cnt_load),
    .en_i      (cnt_en),
    .load_val_i(CNT_LOAD),
    .zero_o    (cnt_zero)
  );

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    rd_cap     = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_load = 1'b1;
        if (req_wr) begin
          accept  = 1'b1;
          state_d = WR_SETUP;
        end else if (req_rd) begin
          accept  = 1'b1;
          state_d = RD_ACC;
        end
      end
      RD_ACC: begin
        cnt_en    = 1'b1;
        sram_oe_n = io_hit;
        if (cnt_zero) begin
          rd_cap  = 1'b1;
          state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      WR_SETUP: begin
        cnt_load   = 1'b1;
        sram_dq_oe = !io_hit;
        state_d    = WR_ACC;
      end
      WR_ACC: begin
        cnt_en     = 1'b1;
        sram_dq_oe = !io_hit;
        sram_we_n  = io_hit;
        if (cnt_zero) state_d = WR_DONE;
      end
      WR_DONE: begin
        sram_dq_oe = !io_hit;
        done       = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_IO_MAP_EN
      hex_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
      end
`ifdef MEM_IO_MAP_EN
      if (rd_cap) rdata_q <= io_hit ? sw : sram_dq_in;
      if (state_q == WR_DONE && io_hit) hex_q <= wdata_q;
`else
      if (rd_cap) rdata_q <= sram_dq_in;
`endif
    end
  end

  assign rdata       = rdata_q;
  assign sram_addr   = ADDR_W'(addr_q);
  assign sram_dq_out = wdata_q;
  assign sram_ce_n   = 1'b0;
  assign sram_ub_n   = 1'b0;
  assign sram_lb_n   = 1'b0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected reads queued at issue, checked on done.
module tb_mem_ctrl;

  localparam int W  = 2;
  localparam int AW = 20;

  logic          Clk = 1'b0, Reset = 1'b0, req_rd = 1'b0, req_wr = 1'b0;
  logic [15:0]   addr = '0, wdata = '0, sw = '0;
  logic [15:0]   rdata, hex_out, sram_dq_out, sram_dq_in;
  logic [AW-1:0] sram_addr;
  logic          done, busy, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  mem_ctrl #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset(Reset), .req_rd(req_rd), .req_wr(req_wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .sw(sw), .hex_out(hex_out),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 Clk = ~Clk;

  int vec = 0, miss = 0;

  typedef struct {bit is_rd; logic [15:0] data;} exp_t;
  exp_t        sb[$];
  logic [15:0] ref_mem[int];
  logic [15:0] exp_hex = '0;

  // SRAM model: 256 words, reads valid only while oe_n is low
  logic [15:0] sram_m[0:255];
  bit          preloaded = 1'b0;
  always @(posedge Clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) sram_m[i] <= (i == 3) ? 16'hBEEF : 16'h0000;
      preloaded <= 1'b1;
    end else if (!sram_we_n && sram_dq_oe) begin
      sram_m[sram_addr[7:0]] <= sram_dq_out;
    end
  end
  assign sram_dq_in = sram_oe_n ? 16'hDEAD : sram_m[sram_addr[7:0]];

  exp_t mon_e;
  always @(negedge Clk) begin
    if (!sram_oe_n && !sram_we_n) begin
      vec++; miss++;
      $display("FAIL strobe_overlap oe_n=%b we_n=%b want never both 0", sram_oe_n, sram_we_n);
    end
    if (done) begin
      if (sb.size() == 0) begin
        vec++; miss++;
        $display("FAIL spurious_done got done=1 want no done (nothing outstanding)");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_rd) begin
          vec++;
          if (rdata !== mon_e.data) begin
            miss++; $display("FAIL rdata got=%h want=%h", rdata, mon_e.data);
          end
        end
      end
    end
  end

  logic tr_we[0:63], tr_oe[0:63], tr_dqoe[0:63];
  logic [AW-1:0] tr_addr[0:63];

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
`ifdef MEM_IO_MAP_EN
    if (a == 16'hFFFF) return sw;
`endif
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  function automatic int cnt_low(input int n, input bit which);
    int c = 0;
    for (int k = 1; k <= n; k++) c += ((which ? tr_we[k] : tr_oe[k]) == 1'b0) ? 1 : 0;
    return c;
  endfunction

  function automatic int cnt_dqoe(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) c += (tr_dqoe[k] == 1'b1) ? 1 : 0;
    return c;
  endfunction

  // One access; inputs scrambled after acceptance to prove they were latched.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                        output int lat);
    exp_t e;
    e.is_rd = rd && !wr;
    e.data  = e.is_rd ? exp_rd(a) : d;
    if (wr) begin
`ifdef MEM_IO_MAP_EN
      if (a == 16'hFFFF) exp_hex = d; else
`endif
      ref_mem[int'(a)] = d;
    end
    sb.push_back(e);
    @(negedge Clk);
    req_rd = rd; req_wr = wr; addr = a; wdata = d;
    @(posedge Clk);
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge Clk);
      tr_we[k] = sram_we_n; tr_oe[k] = sram_oe_n; tr_dqoe[k] = sram_dq_oe; tr_addr[k] = sram_addr;
      if (k == 1) begin req_rd = 0; req_wr = 0; addr = 16'h5A5A; wdata = 16'hA5A5; end
      if (done) lat = k;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    vec++; if (rdata !== 16'h0) begin miss++; $display("FAIL reset_rdata got=%h want=0000", rdata); end
    vec++; if (hex_out !== 16'h0) begin miss++; $display("FAIL reset_hex got=%h want=0000", hex_out); end
    vec++; if ({done, busy} !== 2'b00) begin miss++; $display("FAIL reset_done_busy got=%b want=00", {done, busy}); end
    vec++; if ({sram_oe_n, sram_we_n, sram_dq_oe} !== 3'b110)
      begin miss++; $display("FAIL reset_strobes got=%b want=110", {sram_oe_n, sram_we_n, sram_dq_oe}); end
    vec++; if ({sram_addr, sram_dq_out} !== '0)
      begin miss++; $display("FAIL reset_addr_data got=%h/%h want=0/0", sram_addr, sram_dq_out); end
    vec++; if ({sram_ce_n, sram_ub_n, sram_lb_n} !== 3'b000)
      begin miss++; $display("FAIL tied_strobes got=%b want=000", {sram_ce_n, sram_ub_n, sram_lb_n}); end
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_read;
    int lat;
    access(1'b1, 1'b0, 16'h0003, 16'h0, lat);
    vec++; if (lat != W + 1) begin miss++; $display("FAIL read_latency got=%0d want=%0d", lat, W + 1); end
    vec++; if (cnt_low(lat, 1'b0) != W) begin miss++; $display("FAIL read_oe_cycles got=%0d want=%0d", cnt_low(lat, 1'b0), W); end
    vec++; if (tr_addr[1] !== 20'h00003) begin miss++; $display("FAIL read_addr got=%h want=00003", tr_addr[1]); end
  endtask

  task automatic test_write_readback;
    int lat; bit bad = 0;
    access(1'b0, 1'b1, 16'h0010, 16'h1234, lat);
    vec++; if (lat != W + 2) begin miss++; $display("FAIL write_latency got=%0d want=%0d", lat, W + 2); end
    for (int k = 1; k <= W + 2; k++)
      if (tr_we[k] !== !(k >= 2 && k <= W + 1) || tr_dqoe[k] !== 1'b1 || tr_oe[k] !== 1'b1) bad = 1;
    vec++; if (bad || lat != W + 2) begin miss++; $display("FAIL write_strobe_shape we_low=%0d dq_oe=%0d want %0d/%0d",
      cnt_low(lat, 1'b1), cnt_dqoe(lat), W, W + 2); end
    access(1'b1, 1'b0, 16'h0010, 16'h0, lat);
    vec++; if (lat != W + 1) begin miss++; $display("FAIL readback_latency got=%0d want=%0d", lat, W + 1); end
  endtask

  task automatic test_both;
    int lat;
    access(1'b1, 1'b1, 16'h0020, 16'h5555, lat);
    vec++; if (lat != W + 2 || cnt_low(lat, 1'b0) != 0 || cnt_low(lat, 1'b1) != W)
      begin miss++; $display("FAIL both_req lat=%0d oe_low=%0d we_low=%0d want %0d/0/%0d",
        lat, cnt_low(lat, 1'b0), cnt_low(lat, 1'b1), W + 2, W); end
    repeat (3) @(negedge Clk);
    access(1'b1, 1'b0, 16'h0020, 16'h0, lat);
  endtask

  task automatic test_ignore;
    exp_t e; int ndone = 0, dk = -1; bit moved = 0;
    e.is_rd = 1; e.data = exp_rd(16'h0003); sb.push_back(e);
    @(negedge Clk); req_rd = 1; addr = 16'h0003;
    @(posedge Clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (k <= W && sram_addr !== 20'h00003) moved = 1;
      if (done) begin ndone++; dk = k; end
      if (k == 1) begin req_wr = 1; addr = 16'h0010; wdata = 16'hFFFF; end
      if (k == 2) begin req_rd = 0; req_wr = 0; end
    end
    vec++; if (moved) begin miss++; $display("FAIL ignore_addr got=moved want=00003 held"); end
    vec++; if (ndone != 1 || dk != W + 1) begin miss++; $display("FAIL ignore_done got=%0d@%0d want=1@%0d", ndone, dk, W + 1); end
  endtask

  task automatic test_back_to_back;
    exp_t e; int d1 = -1, d2 = -1; logic b_gap = 1'bx;
    e.is_rd = 1; e.data = exp_rd(16'h0003); sb.push_back(e);
    e.data = exp_rd(16'h0010); sb.push_back(e);
    @(negedge Clk); req_rd = 1; addr = 16'h0003;
    @(posedge Clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (done) begin if (d1 < 0) d1 = k; else d2 = k; end
      if (k == 1) addr = 16'h0010;
      if (k == W + 2) b_gap = busy;
      if (k == W + 3) req_rd = 0;
    end
    vec++; if (d1 != W + 1 || d2 != 2 * W + 3)
      begin miss++; $display("FAIL b2b_done got=%0d,%0d want=%0d,%0d", d1, d2, W + 1, 2 * W + 3); end
    vec++; if (b_gap !== 1'b0) begin miss++; $display("FAIL b2b_idle_gap busy got=%b want=0", b_gap); end
  endtask

  task automatic test_io;
    int lat;
    sw = 16'h00A5;
`ifdef MEM_IO_MAP_EN
    access(1'b1, 1'b0, 16'hFFFF, 16'h0, lat);
    vec++; if (lat != W + 1 || cnt_low(lat, 1'b0) != 0)
      begin miss++; $display("FAIL io_read lat=%0d oe_low=%0d want %0d/0", lat, cnt_low(lat, 1'b0), W + 1); end
    access(1'b0, 1'b1, 16'hFFFF, 16'h4321, lat);
    vec++; if (cnt_low(lat, 1'b1) != 0 || cnt_dqoe(lat) != 0)
      begin miss++; $display("FAIL io_write we_low=%0d dq_oe=%0d want 0/0", cnt_low(lat, 1'b1), cnt_dqoe(lat)); end
    @(negedge Clk);
    vec++; if (hex_out !== exp_hex) begin miss++; $display("FAIL io_hex got=%h want=%h", hex_out, exp_hex); end
`else
    access(1'b0, 1'b1, 16'hFFFF, 16'h7777, lat);
    vec++; if (cnt_low(lat, 1'b1) != W) begin miss++; $display("FAIL ffff_write we_low=%0d want=%0d", cnt_low(lat, 1'b1), W); end
    access(1'b1, 1'b0, 16'hFFFF, 16'h0, lat);
    vec++; if (hex_out !== 16'h0) begin miss++; $display("FAIL hex_const got=%h want=0000", hex_out); end
`endif
  endtask

  task automatic test_reset_mid;
    int lat; bit got_done = 0;
    @(negedge Clk); req_wr = 1; addr = 16'h0030; wdata = 16'hAAAA;
    @(posedge Clk);
    @(negedge Clk); req_wr = 0;
    @(negedge Clk);
    @(negedge Clk);
    vec++; if (sram_we_n !== 1'b0) begin miss++; $display("FAIL mid_pre_we got=%b want=0", sram_we_n); end
    #2 Reset = 1'b0;
    #1;
    vec++; if ({sram_we_n, sram_dq_oe, busy} !== 3'b100)
      begin miss++; $display("FAIL mid_async got we_n/dq_oe/busy=%b want=100", {sram_we_n, sram_dq_oe, busy}); end
    repeat (3) begin @(negedge Clk); if (done) got_done = 1; end
    Reset = 1'b1;
    repeat (2) begin @(negedge Clk); if (done) got_done = 1; end
    vec++; if (got_done) begin miss++; $display("FAIL mid_no_done got=done want=none"); end
    access(1'b1, 1'b0, 16'h0003, 16'h0, lat);
    vec++; if (lat != W + 1) begin miss++; $display("FAIL post_reset_latency got=%0d want=%0d", lat, W + 1); end
  endtask

  initial begin
    ref_mem[3] = 16'hBEEF;
    test_reset;
    test_read;
    test_write_readback;
    test_both;
    test_ignore;
    test_back_to_back;
    test_io;
    test_reset_mid;
    repeat (3) @(negedge Clk);
    vec++; if (sb.size() != 0) begin miss++; $display("FAIL missing_done got=%0d outstanding want=0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
